net_sequencer: RTL and testbench
================================

// Module: net_sequencer
// PURPOSE
// - Upstream driver for a layer stack of unit1to3/unit3to3 cells.
// - Accepts one training/inference sample over a valid/ready handshake and drives it onto the first-layer fin bits.
// - Generates the fd_prop, bk_prop and oscillator phase signals.
// - Captures the last-layer fout bits, drives per-output error bits onto bin, and returns the network result downstream.
// PARAMETERS
// - N_IN     8  number of first-layer fin bits
// - N_OUT    4  number of last-layer fout/bin bits
// - DEPTH    4  layer count; cycles each propagation phase lasts (>=1)
// - OSC_DIV  2  oscillator half-period in cycles (>=1)
// PORTS
// - clk_in        in   1      clock; all logic on posedge
// - rst_in        in   1      synchronous, active-high reset
// - s_valid       in   1      sample offered
// - s_ready       out  1      sequencer can accept a sample
// - s_data        in   N_IN   sample input bits
// - s_target      in   N_OUT  expected output bits
// - s_train       in   1      1 = run backward phase for this sample
// - fin           out  N_IN   to first-layer fin ports
// - fd_prop       out  1      forward-propagate enable to all units
// - bk_prop       out  1      backward-propagate enable to all units
// - oscillator    out  1      update oscillator to all units
// - net_fout      in   N_OUT  last-layer fout bits
// - bin           out  N_OUT  to last-layer bin ports (error bits)
// - r_valid       out  1      result available
// - r_ready       in   1      downstream accepts result
// - r_data        out  N_OUT  captured network output
// - r_err_cnt     out  $clog2(N_OUT+1)  number of outputs != target
// BEHAVIOUR
// - States: IDLE, FWD, CAPT, BWD, DONE.
// - Reset (any cycle, including mid-phase): state=IDLE; all outputs 0 except s_ready=1; counters and held sample cleared.
// - IDLE: s_ready=1. On s_valid&s_ready, register s_data->fin, s_target, s_train and go to FWD.
// - fin stays stable from acceptance until exit of DONE, then returns to 0.
// - FWD: fd_prop=1 for exactly DEPTH cycles (down-counter), then CAPT.
// - CAPT: one cycle, fd_prop=0. At its edge:
//   - r_data<=net_fout
//   - err=net_fout^target
//   - r_err_cnt<=popcount(err)
//   - next state is BWD if train else DONE.
// - BWD: bk_prop=1 and bin=err for exactly DEPTH cycles.
//   - oscillator toggles every OSC_DIV cycles, starting at 0 on BWD entry.
//   - On BWD exit: oscillator forced 0, bin=0, go to DONE.
// - fd_prop and bk_prop are never high in the same cycle; oscillator is 0 outside BWD.
// - DONE: r_valid=1; r_data/r_err_cnt held stable while r_valid&!r_ready.
//   - On r_valid&r_ready: go to IDLE; r_valid drops the next cycle.
// - s_ready is 0 in every state except IDLE; s_valid outside IDLE is ignored (no buffering).
// - Latency, acceptance edge to r_valid high:
//   - inference: DEPTH+2 cycles
//   - training: 2*DEPTH+2 cycles
// - Throughput: one sample per (latency + 1 + downstream stall) cycles; the IDLE cycle between samples is mandatory.
// - r_err_cnt saturates at nothing: its width holds N_OUT exactly; a target of all bits wrong gives N_OUT.
// TESTING
// - Reset mid-BWD (DEPTH=4, cycle 2 of BWD) -> next cycle:
//   - bk_prop=0, oscillator=0, bin=0, r_valid=0, s_ready=1
//   - a new sample is accepted normally.
// - Inference: s_data=8'hA5, s_train=0, net_fout tied 4'b1010, target 4'b1010:
//   - fd_prop high 4 cycles, bk_prop never high
//   - r_valid at +6, r_data=4'b1010, r_err_cnt=0.
// - Training: target 4'b0000, net_fout 4'b1011:
//   - bk_prop high 4 cycles with bin=4'b1011
//   - oscillator (OSC_DIV=2) = 0,0,1,1 over BWD
//   - r_valid at +10, r_err_cnt=3.
// - Backpressure: hold r_ready=0 for 5 cycles in DONE:
//   - r_valid and r_data stable; s_ready=0; s_valid ignored
//   - r_ready=1 -> IDLE, s_ready=1 the following cycle.
// - Back-to-back: s_valid held high with two samples:
//   - second accepted exactly one cycle after first handshake completes
//   - fin changes only at acceptance.
// - All-wrong: target=4'b1111, net_fout=4'b0000, train=1 -> bin=4'b1111 during BWD, r_err_cnt=4.

Source files
------------

// File: rtl/net_sequencer.sv
// net_sequencer: accepts one sample, sequences forward/capture/backward phases for a unit layer stack,
// and returns the captured network output with its error count.
module net_sequencer #(
    parameter int N_IN    = 8,
    parameter int N_OUT   = 4,
    parameter int DEPTH   = 4,
    parameter int OSC_DIV = 2
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [N_IN-1:0]              s_data,
    input  logic [N_OUT-1:0]             s_target,
    input  logic                         s_train,
    output logic [N_IN-1:0]              fin,
    output logic                         fd_prop,
    output logic                         bk_prop,
    output logic                         oscillator,
    input  logic [N_OUT-1:0]             net_fout,
    output logic [N_OUT-1:0]             bin,
    output logic                         r_valid,
    input  logic                         r_ready,
    output logic [N_OUT-1:0]             r_data,
    output logic [$clog2(N_OUT+1)-1:0]   r_err_cnt
);
    localparam int CW = $clog2(N_OUT + 1);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(OSC_DIV + 1);

    typedef enum logic [2:0] {IDLE, FWD, CAPT, BWD, DONE} state_t;

    state_t           state, state_nxt;
    logic [DW-1:0]    cnt;
    logic [OW-1:0]    div;
    logic             osc;
    logic             train;
    logic [N_OUT-1:0] target, err, err_now;
    logic [CW-1:0]    pop;

    assign err_now    = net_fout ^ target;
    assign s_ready    = state == IDLE;
    assign fd_prop    = state == FWD;
    assign bk_prop    = state == BWD;
    assign oscillator = state == BWD && osc;
    assign bin        = state == BWD ? err : '0;
    assign r_valid    = state == DONE;

    always_comb begin
        pop = '0;
        for (int i = 0; i < N_OUT; i++) pop = pop + CW'(err_now[i]);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = s_valid ? FWD : IDLE;
            FWD:     state_nxt = cnt == '0 ? CAPT : FWD;
            CAPT:    state_nxt = train ? BWD : DONE;
            BWD:     state_nxt = cnt == '0 ? DONE : BWD;
            DONE:    state_nxt = r_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // One down-counter serves both propagation phases; it is reloaded on entry to each.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= IDLE;
            cnt       <= '0;
            div       <= '0;
            osc       <= 1'b0;
            train     <= 1'b0;
            target    <= '0;
            err       <= '0;
            fin       <= '0;
            r_data    <= '0;
            r_err_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (s_valid) begin
                    fin    <= s_data;
                    target <= s_target;
                    train  <= s_train;
                    cnt    <= DW'(DEPTH - 1);
                end
                FWD: cnt <= cnt - DW'(1);
                CAPT: begin
                    r_data    <= net_fout;
                    err       <= err_now;
                    r_err_cnt <= pop;
                    cnt       <= DW'(DEPTH - 1);
                    div       <= '0;
                    osc       <= 1'b0;
                end
                BWD: begin
                    cnt <= cnt - DW'(1);
                    div <= div == OW'(OSC_DIV - 1) ? '0 : div + OW'(1);
                    osc <= div == OW'(OSC_DIV - 1) ? ~osc : osc;
                end
                DONE: if (r_ready) fin <= '0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_net_sequencer.sv
// tb_net_sequencer: directed scenarios for net_sequencer with DEPTH=4, OSC_DIV=2.
// Trace index k counts falling edges after the acceptance edge (k=1 is the first cycle in FWD).
module tb_net_sequencer;
    logic       clk_in = 0;
    logic       rst_in = 1;
    logic       s_valid = 0;
    logic       s_ready;
    logic [7:0] s_data = 0;
    logic [3:0] s_target = 0;
    logic       s_train = 0;
    logic [7:0] fin;
    logic       fd_prop, bk_prop, oscillator;
    logic [3:0] net_fout = 0;
    logic [3:0] bin;
    logic       r_valid;
    logic       r_ready = 0;
    logic [3:0] r_data;
    logic [2:0] r_err_cnt;

    int checks = 0;
    int failures = 0;

    logic [15:1] fd_v, bk_v, osc_v, rv_v, sr_v;
    logic [3:0]  bin_t [1:15];
    logic [7:0]  fin_t [1:15];

    net_sequencer dut (
        .clk_in(clk_in), .rst_in(rst_in), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_target(s_target), .s_train(s_train), .fin(fin),
        .fd_prop(fd_prop), .bk_prop(bk_prop), .oscillator(oscillator),
        .net_fout(net_fout), .bin(bin), .r_valid(r_valid), .r_ready(r_ready),
        .r_data(r_data), .r_err_cnt(r_err_cnt)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic accept(input logic [7:0] d, input logic [3:0] t, input logic tr);
        @(negedge clk_in);
        s_data = d; s_target = t; s_train = tr; s_valid = 1;
        @(posedge clk_in);
        #1 s_valid = 0;
    endtask

    task automatic record(input int n);
        fd_v = '0; bk_v = '0; osc_v = '0; rv_v = '0; sr_v = '0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk_in);
            fd_v[k] = fd_prop; bk_v[k] = bk_prop; osc_v[k] = oscillator;
            rv_v[k] = r_valid; sr_v[k] = s_ready;
            bin_t[k] = bin; fin_t[k] = fin;
        end
    endtask

    task automatic release_result();
        @(negedge clk_in);
        r_ready = 1;
        @(posedge clk_in);
        #1 r_ready = 0;
    endtask

    task automatic test_reset();
        rst_in = 1;
        repeat (2) @(posedge clk_in);
        #1 rst_in = 0;
        @(negedge clk_in);
        checks++;
        if ({s_ready, fd_prop, bk_prop, oscillator, r_valid} !== 5'b10000) begin
            failures++; $display("FAIL reset_ctrl got=%b want=10000", {s_ready, fd_prop, bk_prop, oscillator, r_valid});
        end
        checks++;
        if ({fin, bin, r_data, r_err_cnt} !== 19'd0) begin
            failures++; $display("FAIL reset_data got fin=%h bin=%b r_data=%b cnt=%0d want all 0", fin, bin, r_data, r_err_cnt);
        end
    endtask

    task automatic test_inference();
        net_fout = 4'b1010;
        accept(8'hA5, 4'b1010, 0);
        record(6);
        checks++;
        if (fd_v !== 15'h000F) begin failures++; $display("FAIL inf_fd got=%h want=000f", fd_v); end
        checks++;
        if (bk_v !== 15'h0000) begin failures++; $display("FAIL inf_bk got=%h want=0000", bk_v); end
        checks++;
        if (rv_v !== 15'h0020) begin failures++; $display("FAIL inf_rvalid got=%h want=0020", rv_v); end
        checks++;
        if (r_data !== 4'b1010 || r_err_cnt !== 3'd0) begin
            failures++; $display("FAIL inf_result got data=%b cnt=%0d want 1010/0", r_data, r_err_cnt);
        end
        checks++;
        if (fin !== 8'hA5 || sr_v !== 15'h0000) begin
            failures++; $display("FAIL inf_fin got fin=%h sready=%h want a5/0000", fin, sr_v);
        end
        release_result();
        @(negedge clk_in);
        checks++;
        if ({s_ready, r_valid, fin} !== {2'b10, 8'h00}) begin
            failures++; $display("FAIL inf_release got sready=%b rvalid=%b fin=%h want 1/0/00", s_ready, r_valid, fin);
        end
    endtask

    task automatic test_training();
        net_fout = 4'b1011;
        accept(8'h3C, 4'b0000, 1);
        record(10);
        checks++;
        if (fd_v !== 15'h000F) begin failures++; $display("FAIL trn_fd got=%h want=000f", fd_v); end
        checks++;
        if (bk_v !== 15'h01E0) begin failures++; $display("FAIL trn_bk got=%h want=01e0", bk_v); end
        checks++;
        if (osc_v !== 15'h0180) begin failures++; $display("FAIL trn_osc got=%h want=0180", osc_v); end
        checks++;
        if ((fd_v & bk_v) !== 15'h0000) begin failures++; $display("FAIL trn_overlap got=%h want=0000", fd_v & bk_v); end
        for (int k = 1; k <= 10; k++) begin
            checks++;
            if (bin_t[k] !== ((k >= 6 && k <= 9) ? 4'b1011 : 4'b0000)) begin
                failures++; $display("FAIL trn_bin k=%0d got=%b want=%b", k, bin_t[k], (k >= 6 && k <= 9) ? 4'b1011 : 4'b0000);
            end
        end
        checks++;
        if (rv_v !== 15'h0200) begin failures++; $display("FAIL trn_rvalid got=%h want=0200", rv_v); end
        checks++;
        if (r_data !== 4'b1011 || r_err_cnt !== 3'd3) begin
            failures++; $display("FAIL trn_result got data=%b cnt=%0d want 1011/3", r_data, r_err_cnt);
        end
        release_result();
    endtask

    task automatic test_backpressure();
        net_fout = 4'b0110;
        accept(8'h5A, 4'b0011, 0);
        record(6);
        @(negedge clk_in);
        s_valid = 1; s_data = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_in);
            checks++;
            if ({r_valid, s_ready, r_data, r_err_cnt, fin} !== {2'b10, 4'b0110, 3'd2, 8'h5A}) begin
                failures++;
                $display("FAIL bp_hold k=%0d got rvalid=%b sready=%b data=%b cnt=%0d fin=%h want 1/0/0110/2/5a",
                         k, r_valid, s_ready, r_data, r_err_cnt, fin);
            end
        end
        s_valid = 0;
        r_ready = 1;
        @(posedge clk_in);
        #1 r_ready = 0;
        @(negedge clk_in);
        checks++;
        if ({s_ready, r_valid} !== 2'b10) begin
            failures++; $display("FAIL bp_release got sready=%b rvalid=%b want 1/0", s_ready, r_valid);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        net_fout = 4'b0001;
        @(negedge clk_in);
        s_valid = 1; s_data = 8'h11; s_target = 4'b0001; s_train = 0; r_ready = 1;
        @(posedge clk_in);
        #1 s_data = 8'h22;
        record(7);
        @(posedge clk_in);
        #1 s_valid = 0;
        @(negedge clk_in);
        for (int k = 1; k <= 7; k++) begin
            checks++;
            if (fin_t[k] !== (k <= 6 ? 8'h11 : 8'h00)) begin
                failures++; $display("FAIL b2b_fin k=%0d got=%h want=%h", k, fin_t[k], k <= 6 ? 8'h11 : 8'h00);
            end
        end
        checks++;
        if (sr_v !== 15'h0040) begin failures++; $display("FAIL b2b_sready got=%h want=0040", sr_v); end
        checks++;
        if (fin !== 8'h22 || fd_prop !== 1'b1) begin
            failures++; $display("FAIL b2b_second got fin=%h fd=%b want 22/1", fin, fd_prop);
        end
        n = 0;
        while (!(s_ready && !r_valid) && n < 30) begin @(negedge clk_in); n++; end
        r_ready = 0;
        checks++;
        if (n >= 30) begin failures++; $display("FAIL b2b_drain got timeout want idle within 30 cycles"); end
    endtask

    task automatic test_all_wrong();
        net_fout = 4'b0000;
        accept(8'hF0, 4'b1111, 1);
        record(10);
        for (int k = 6; k <= 9; k++) begin
            checks++;
            if (bin_t[k] !== 4'b1111) begin failures++; $display("FAIL aw_bin k=%0d got=%b want=1111", k, bin_t[k]); end
        end
        checks++;
        if (rv_v[10] !== 1'b1 || r_err_cnt !== 3'd4 || r_data !== 4'b0000) begin
            failures++; $display("FAIL aw_result got rvalid=%b cnt=%0d data=%b want 1/4/0000", rv_v[10], r_err_cnt, r_data);
        end
        release_result();
    endtask

    task automatic test_reset_mid_bwd();
        net_fout = 4'b1100;
        accept(8'h77, 4'b0011, 1);
        record(7);
        checks++;
        if (bk_v[7] !== 1'b1 || bin_t[7] !== 4'b1111) begin
            failures++; $display("FAIL rst_bwd_pre got bk=%b bin=%b want 1/1111", bk_v[7], bin_t[7]);
        end
        rst_in = 1;
        @(posedge clk_in);
        #1 rst_in = 0;
        @(negedge clk_in);
        checks++;
        if ({bk_prop, oscillator, bin, r_valid, s_ready, fd_prop, fin} !== {1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL rst_bwd got bk=%b osc=%b bin=%b rvalid=%b sready=%b fd=%b fin=%h want 0/0/0000/0/1/0/00",
                     bk_prop, oscillator, bin, r_valid, s_ready, fd_prop, fin);
        end
        net_fout = 4'b0101;
        accept(8'h99, 4'b0100, 0);
        record(6);
        checks++;
        if (rv_v !== 15'h0020 || r_data !== 4'b0101 || r_err_cnt !== 3'd1 || fin !== 8'h99) begin
            failures++; $display("FAIL rst_bwd_after got rv=%h data=%b cnt=%0d fin=%h want 0020/0101/1/99", rv_v, r_data, r_err_cnt, fin);
        end
        release_result();
    endtask

    initial begin
        test_reset();
        test_inference();
        test_training();
        test_backpressure();
        test_back_to_back();
        test_all_wrong();
        test_reset_mid_bwd();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
